// File: rtl/alu_reg_file.sv
// ---------------------------------------------------------------------------
// alu_reg_file
//
// Operand/result register stage of the 8-bit ALU datapath. Two operands are
// captured from a packed 24-bit word, and the ALU's 16-bit result is reduced
// to a registered 8-bit answer. Every output comes straight from a flop, so
// there is no combinational path from any input to any output.
//
// Configuration macro: REG_FILE_SAT_EN
//   undefined (default): y takes result[7:0] and the high byte is ignored.
//   defined            : y saturates to 8'hFF whenever result[15:8] != 0.
//
// Ports:
//   clock    in   1   rising-edge clock for all state
//   reset_n  in   1   asynchronous, active-low reset (clears a, b, y)
//   data     in  24   [23:16] operand A, [15:8] operand B, [7:0] reserved
//   result   in  16   ALU result, [15:8] high byte, [7:0] low byte
//   a        out  8   registered operand A
//   b        out  8   registered operand B
//   y        out  8   registered 8-bit result
// ---------------------------------------------------------------------------
module alu_reg_file (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [23:0] data,
  input  logic [15:0] result,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [7:0]  y
);

  logic [7:0] ra_q;
  logic [7:0] rb_q;
  logic [7:0] ry_q;
  logic [7:0] ra_d;
  logic [7:0] rb_d;
  logic [7:0] ry_d;

`ifdef REG_FILE_SAT_EN
  // Any non-zero high byte means the true result cannot fit in 8 bits.
  function automatic logic [7:0] resolve_result(input logic [15:0] res);
    logic [7:0] out_v;
    if (res[15:8] != 8'h00) begin
      out_v = 8'hFF;
    end else begin
      out_v = res[7:0];
    end
    return out_v;
  endfunction

  // The reserved operand byte never reaches any output.
  logic unused_bits_s;
  assign unused_bits_s = ^data[7:0];
`else
  // Truncating build: only the low result byte is kept.
  function automatic logic [7:0] resolve_result(input logic [7:0] res_lo);
    return res_lo;
  endfunction

  // Reserved operand byte and the result high byte are deliberately dropped.
  logic unused_bits_s;
  assign unused_bits_s = ^{data[7:0], result[15:8]};
`endif

  // Next-state selection for the operand and result registers.
  always_comb begin
    ra_d = data[23:16];
    rb_d = data[15:8];
`ifdef REG_FILE_SAT_EN
    ry_d = resolve_result(result);
`else
    ry_d = resolve_result(result[7:0]);
`endif
  end

  // State registers: load every edge, cleared asynchronously by reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ra_q <= 8'h00;
      rb_q <= 8'h00;
      ry_q <= 8'h00;
    end else begin
      ra_q <= ra_d;
      rb_q <= rb_d;
      ry_q <= ry_d;
    end
  end

  assign a = ra_q;
  assign b = rb_q;
  assign y = ry_q;

endmodule

// File: tb/tb_alu_reg_file.sv
module tb_alu_reg_file;

  logic        clock;
  logic        reset_n;
  logic [23:0] data;
  logic [15:0] result;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  y;

  int total;
  int bad;

  alu_reg_file dut (
    .clock   (clock),
    .reset_n (reset_n),
    .data    (data),
    .result  (result),
    .a       (a),
    .b       (b),
    .y       (y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset_n = 1'b1;
    data    = 24'hA5C3E7;
    result  = 16'hBEEF;
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (a !== 8'h00 || b !== 8'h00 || y !== 8'h00) begin
      bad++;
      $display("FAIL reset_no_clock: a=%h b=%h y=%h required 00/00/00", a, b, y);
    end
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (a !== 8'h00 || b !== 8'h00 || y !== 8'h00) begin
      bad++;
      $display("FAIL reset_held: a=%h b=%h y=%h required 00/00/00", a, b, y);
    end
  endtask

  task automatic test_operand_capture();
    @(negedge clock);
    data    = 24'h7FBEBD;
    result  = 16'h0000;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (a !== 8'h7F || b !== 8'hBE || y !== 8'h00) begin
      bad++;
      $display("FAIL operand_capture: a=%h b=%h y=%h required 7f/be/00", a, b, y);
    end
    // Reserved byte changes only; outputs must not move.
    @(negedge clock);
    data = 24'h7FBE42;
    @(posedge clock);
    #1;
    total++;
    if (a !== 8'h7F || b !== 8'hBE || y !== 8'h00) begin
      bad++;
      $display("FAIL reserved_byte: a=%h b=%h y=%h required 7f/be/00", a, b, y);
    end
  endtask

  task automatic test_result_capture();
    @(negedge clock);
    result = 16'h0035;
    #1;
    total++;
    if (y !== 8'h00) begin
      bad++;
      $display("FAIL result_mid_cycle: y=%h required 00", y);
    end
    @(posedge clock);
    #1;
    total++;
    if (y !== 8'h35 || a !== 8'h7F || b !== 8'hBE) begin
      bad++;
      $display("FAIL result_capture: a=%h b=%h y=%h required 7f/be/35", a, b, y);
    end
  endtask

  task automatic test_high_byte();
    logic [7:0] exp_0135;
    logic [7:0] exp_8000;
`ifdef REG_FILE_SAT_EN
    exp_0135 = 8'hFF;
    exp_8000 = 8'hFF;
`else
    exp_0135 = 8'h35;
    exp_8000 = 8'h00;
`endif
    @(negedge clock);
    result = 16'h0135;
    @(posedge clock);
    #1;
    total++;
    if (y !== exp_0135) begin
      bad++;
      $display("FAIL high_byte_0135: y=%h required %h", y, exp_0135);
    end
    @(negedge clock);
    result = 16'h00FF;
    @(posedge clock);
    #1;
    total++;
    if (y !== 8'hFF) begin
      bad++;
      $display("FAIL high_byte_00ff: y=%h required ff", y);
    end
    @(negedge clock);
    result = 16'h8000;
    @(posedge clock);
    #1;
    total++;
    if (y !== exp_8000) begin
      bad++;
      $display("FAIL high_byte_8000: y=%h required %h", y, exp_8000);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    result = 16'h0012;
    #1;
    total++;
    if (a !== 8'h7F) begin
      bad++;
      $display("FAIL async_pre: a=%h required 7f", a);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (a !== 8'h00 || b !== 8'h00 || y !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: a=%h b=%h y=%h required 00/00/00", a, b, y);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (a !== 8'h7F || b !== 8'hBE || y !== 8'h12) begin
      bad++;
      $display("FAIL async_reload: a=%h b=%h y=%h required 7f/be/12", a, b, y);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] vec [3];
    vec[0] = 24'h010200;
    vec[1] = 24'hFFFF00;
    vec[2] = 24'h000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      data = vec[i];
      @(posedge clock);
      #1;
      total++;
      if (a !== vec[i][23:16] || b !== vec[i][15:8]) begin
        bad++;
        $display("FAIL back_to_back[%0d]: a=%h b=%h required %h/%h",
                 i, a, b, vec[i][23:16], vec[i][15:8]);
      end
    end
    // Held inputs keep the outputs steady.
    @(posedge clock);
    #1;
    total++;
    if (a !== 8'h00 || b !== 8'h00 || y !== 8'h12) begin
      bad++;
      $display("FAIL held_inputs: a=%h b=%h y=%h required 00/00/12", a, b, y);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_operand_capture();
    test_result_capture();
    test_high_byte();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
